mips_mem_sequencer: RTL and testbench

MIPS_MEM_SEQUENCER -- requirements
Module: mips_mem_sequencer

---
 rtl/mips_ctrl_pkg.sv | 24 ++
 rtl/mips_opcode_decode.sv | 49 ++++
 rtl/mips_mem_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mips_mem_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS memory sequencer: opcode values, SIZE
// encodings and the sequencer state enum.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned SIZE_W   = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LB    = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_LH    = 6'b100001;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational opcode classifier for the memory sequencer.
// Ports:
//   opcode     - 6-bit MIPS primary opcode
//   is_mem     - opcode is a supported load/store
//   is_write   - opcode is a store
//   size       - access size encoding (byte/half/word)
//   is_illegal - opcode is neither a supported memory op nor R-type
module mips_opcode_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output logic                is_mem,
  output logic                is_write,
  output logic [SIZE_W-1:0]   size,
  output logic                is_illegal
);

  // R-type falls through with every flag low: accepted but no memory access.
  always_comb begin
    is_mem     = 1'b0;
    is_write   = 1'b0;
    size       = SIZE_BYTE;
    is_illegal = 1'b0;
    case (opcode)
      OP_LW: begin
        is_mem = 1'b1;
        size   = SIZE_WORD;
      end
      OP_SW: begin
        is_mem   = 1'b1;
        is_write = 1'b1;
        size     = SIZE_WORD;
      end
      OP_LB: begin
        is_mem = 1'b1;
      end
      OP_LH: begin
        is_mem = 1'b1;
        size   = SIZE_HALF;
      end
      OP_RTYPE: begin
      end
      default: begin
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mips_mem_sequencer.sv
// Memory access sequencer: accepts one load/store opcode at a time and
// drives a (possibly multi-beat) memory request until the last beat is
// acknowledged, then pulses DONE for one cycle.
// Optional feature: define MIPS_SEQ_TIMEOUT_EN to abort a transfer with
// DONE+ERR after TIMEOUT_CYC consecutive cycles without MEM_ACK.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   OPCODE, OP_VALID   - opcode input and its valid
//   OP_READY           - high only while idle
//   MEM_ACK            - memory accepted/returned the current beat
//   ENABLE/WRITE/SIZE  - memory request qualifiers
//   BURST, BUSY, BEAT  - transfer status and current beat index
//   DONE, ILLEGAL, ERR - single-cycle event pulses
module mips_mem_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = $clog2(BURST_LEN) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                OP_VALID,
  output logic                OP_READY,
  input  logic                MEM_ACK,
  output logic                ENABLE,
  output logic                WRITE,
  output logic                BURST,
  output logic                BUSY,
  output logic [SIZE_W-1:0]   SIZE,
  output logic [CNT_W-1:0]    BEAT,
  output logic                DONE,
  output logic                ILLEGAL,
  output logic                ERR
);

  if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst
    $error("BURST_LEN out of range 1..16");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    last_q, last_d;
  logic                op_ready_d, enable_d, write_d, burst_d, busy_d;
  logic                done_d, illegal_d, err_d, timeout_c;
  logic [SIZE_W-1:0]   size_d;
  logic [CNT_W-1:0]    beat_d;
  logic                dec_is_mem, dec_is_write, dec_is_illegal;
  logic [SIZE_W-1:0]   dec_size;

  mips_opcode_decode u_decode (
    .opcode     (OPCODE),
    .is_mem     (dec_is_mem),
    .is_write   (dec_is_write),
    .size       (dec_size),
    .is_illegal (dec_is_illegal)
  );

`ifdef MIPS_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0] to_cnt_q;

  // Consecutive XFER cycles without an ack; cleared by any ack or on leaving XFER.
  always_ff @(posedge clk) begin
    if (!rst_n || state_q != ST_XFER || MEM_ACK) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout_c = (state_q == ST_XFER) && !MEM_ACK &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and next-output logic; outputs hold unless a transition updates them.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    op_ready_d = OP_READY;
    enable_d   = ENABLE;
    write_d    = WRITE;
    burst_d    = BURST;
    busy_d     = BUSY;
    size_d     = SIZE;
    beat_d     = BEAT;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (OP_VALID && OP_READY) begin
          if (dec_is_mem) begin
            state_d    = ST_XFER;
            op_ready_d = 1'b0;
            enable_d   = 1'b1;
            busy_d     = 1'b1;
            write_d    = dec_is_write;
            size_d     = dec_size;
            beat_d     = '0;
            burst_d    = (dec_size == SIZE_WORD) && (BURST_LEN > 1);
            last_d     = (dec_size == SIZE_WORD) ? CNT_W'(BURST_LEN - 1) : '0;
          end else if (dec_is_illegal) begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_XFER: begin
        if ((MEM_ACK && BEAT == last_q) || timeout_c) begin
          state_d  = ST_DONE;
          enable_d = 1'b0;
          write_d  = 1'b0;
          burst_d  = 1'b0;
          size_d   = SIZE_BYTE;
          done_d   = 1'b1;
          err_d    = timeout_c;
        end else if (MEM_ACK) begin
          beat_d = BEAT + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        op_ready_d = 1'b1;
        beat_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= '0;
      OP_READY <= 1'b1;
      ENABLE   <= 1'b0;
      WRITE    <= 1'b0;
      BURST    <= 1'b0;
      BUSY     <= 1'b0;
      SIZE     <= SIZE_BYTE;
      BEAT     <= '0;
      DONE     <= 1'b0;
      ILLEGAL  <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      OP_READY <= op_ready_d;
      ENABLE   <= enable_d;
      WRITE    <= write_d;
      BURST    <= burst_d;
      BUSY     <= busy_d;
      SIZE     <= size_d;
      BEAT     <= beat_d;
      DONE     <= done_d;
      ILLEGAL  <= illegal_d;
`ifdef MIPS_SEQ_TIMEOUT_EN
      ERR      <= err_d;
`else
      ERR      <= 1'b0;
`endif
    end
  end

`ifndef MIPS_SEQ_TIMEOUT_EN
  logic unused_err;
  assign unused_err = err_d;
`endif

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Directed self-checking bench for mips_mem_sequencer (BURST_LEN=4,
// TIMEOUT_CYC=8). Observed vector layout:
// {OP_READY,ENABLE,WRITE,BURST,BUSY,DONE,ILLEGAL,ERR,SIZE[1:0],BEAT[2:0]}
module tb_mips_mem_sequencer;

  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = 6'b0;
  logic             op_valid = 1'b0;
  logic             mem_ack = 1'b0;
  logic             op_ready, enable, write, burst, busy, done, illegal, err;
  logic [1:0]       size;
  logic [CNT_W-1:0] beat;
  logic [12:0]      obs;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [12:0] IDLE_V = 13'b1_0_0_0_0_0_0_0_00_000;

  mips_mem_sequencer #(
    .BURST_LEN   (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .OPCODE   (opcode),
    .OP_VALID (op_valid),
    .OP_READY (op_ready),
    .MEM_ACK  (mem_ack),
    .ENABLE   (enable),
    .WRITE    (write),
    .BURST    (burst),
    .BUSY     (busy),
    .SIZE     (size),
    .BEAT     (beat),
    .DONE     (done),
    .ILLEGAL  (illegal),
    .ERR      (err)
  );

  always #5 clk = ~clk;

  assign obs = {op_ready, enable, write, burst, busy, done, illegal, err, size, beat};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL reset obs=%b exp=%b", obs, IDLE_V);
    end
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL reset_idle obs=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_lw_burst();
    logic [12:0] exp;
    opcode = 6'b100011; op_valid = 1'b1; mem_ack = 1'b1;
    step();
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = {11'b0_1_0_1_1_0_0_0_10, 3'(i)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL lw_beat%0d obs=%b exp=%b", i, obs, exp);
      end
      step();
    end
    exp = 13'b0_0_0_0_1_1_0_0_00_011;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL lw_done obs=%b exp=%b", obs, exp);
    end
    step();
    mem_ack = 1'b0;
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL lw_idle obs=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_lb_delayed_ack();
    logic [12:0] exp;
    opcode = 6'b100000; op_valid = 1'b1; mem_ack = 1'b0;
    step();
    op_valid = 1'b0;
    exp = 13'b0_1_0_0_1_0_0_0_00_000;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL lb_wait%0d obs=%b exp=%b", i, obs, exp);
      end
      step();
    end
    mem_ack = 1'b1;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL lb_ack_cycle obs=%b exp=%b", obs, exp);
    end
    step();
    mem_ack = 1'b0;
    exp = 13'b0_0_0_0_1_1_0_0_00_000;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL lb_done obs=%b exp=%b", obs, exp);
    end
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL lb_idle obs=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_illegal();
    logic [12:0] exp;
    opcode = 6'b111111; op_valid = 1'b1;
    step();
    opcode = 6'b000000;
    exp = 13'b1_0_0_0_0_0_1_0_00_000;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL illegal_pulse obs=%b exp=%b", obs, exp);
    end
    step();
    op_valid = 1'b0;
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL rtype_quiet obs=%b exp=%b", obs, IDLE_V);
    end
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL illegal_idle obs=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_sw_ignores_pending();
    logic [12:0] exp;
    opcode = 6'b101011; op_valid = 1'b1; mem_ack = 1'b1;
    step();
    opcode = 6'b100001;
    for (int i = 0; i < 4; i++) begin
      exp = {11'b0_1_1_1_1_0_0_0_10, 3'(i)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL sw_beat%0d obs=%b exp=%b", i, obs, exp);
      end
      step();
    end
    exp = 13'b0_0_0_0_1_1_0_0_00_011;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL sw_done obs=%b exp=%b", obs, exp);
    end
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL sw_idle obs=%b exp=%b", obs, IDLE_V);
    end
    step();
    op_valid = 1'b0;
    exp = 13'b0_1_0_0_1_0_0_0_01_000;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL lh_after_idle obs=%b exp=%b", obs, exp);
    end
    step();
    step();
    mem_ack = 1'b0;
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL lh_idle obs=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_reset_mid_xfer();
    logic [12:0] exp;
    opcode = 6'b100011; op_valid = 1'b1; mem_ack = 1'b1;
    step();
    op_valid = 1'b0;
    step();
    step();
    exp = 13'b0_1_0_1_1_0_0_0_10_010;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL mid_beat2 obs=%b exp=%b", obs, exp);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mem_ack = 1'b0;
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL mid_reset obs=%b exp=%b", obs, IDLE_V);
    end
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL mid_no_done obs=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_timeout();
    logic [12:0] exp;
    opcode = 6'b100011; op_valid = 1'b1; mem_ack = 1'b0;
    step();
    op_valid = 1'b0;
    exp = 13'b0_1_0_1_1_0_0_0_10_000;
`ifdef MIPS_SEQ_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL to_wait%0d obs=%b exp=%b", i, obs, exp);
      end
      step();
    end
    exp = 13'b0_0_0_0_1_1_0_1_00_000;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL to_done_err obs=%b exp=%b", obs, exp);
    end
    step();
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL to_idle obs=%b exp=%b", obs, IDLE_V);
    end
`else
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL hold_wait%0d obs=%b exp=%b", i, obs, exp);
      end
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if (obs !== IDLE_V) begin
      miscompares++;
      $display("FAIL hold_reset obs=%b exp=%b", obs, IDLE_V);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lw_burst();
    test_lb_delayed_ack();
    test_illegal();
    test_sw_ignores_pending();
    test_reset_mid_xfer();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
